// File: rtl/bq_coef_loader.sv
// Wishbone initiator that writes the five biquad coefficients (a11, a12, b10, b11, b12) in address order.
// Define BQLOAD_VERIFY_EN to follow each write with a readback and compare.
module bq_coef_loader #(
   parameter logic [31:0] BASE_ADR = 32'h0,
   parameter logic [31:0] ADR_STEP = 32'h1,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   input  logic [15:0] a11_i,
   input  logic [15:0] a12_i,
   input  logic [15:0] b10_i,
   input  logic [15:0] b11_i,
   input  logic [15:0] b12_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [2:0]  err_idx_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   // state    | meaning
   // S_IDLE   | waiting for start_i
   // S_WR     | write strobe for coefficient idx
   // S_WR_GAP | one idle bus cycle after a write
   // S_RD     | readback strobe for coefficient idx (verify build)
   // S_RD_GAP | one idle bus cycle after a readback (verify build)
   // S_FIN    | done_o pulse, back to idle
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR     = 3'd1,
      S_WR_GAP = 3'd2,
      S_RD     = 3'd3,
      S_RD_GAP = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);
   localparam logic [2:0]  IDX_LAST = 3'd4;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_idx;
   logic [2:0]  w_idx_nxt;
   logic [15:0] r_tmo;
   logic [15:0] w_tmo_nxt;
   logic [15:0] r_coef [0:4];

   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [2:0]  r_err_idx;
   logic        r_cyc;
   logic        r_stb;
   logic        r_we;
   logic [31:0] r_adr;
   logic [31:0] r_dat;

   logic        w_latch;
   logic        w_err_nxt;
   logic [2:0]  w_err_idx_nxt;
   logic        w_xfer_nxt;
   logic        w_we_nxt;
   logic        w_busy_nxt;
   logic [31:0] w_adr_nxt;
   logic [15:0] w_coef_sel;
   logic        w_unused_dat;

   assign w_unused_dat = ^wbm_dat_i;

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_tmo_nxt     = r_tmo;
      w_err_nxt     = r_err;
      w_err_idx_nxt = r_err_idx;
      w_latch       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt   = S_WR;
               w_idx_nxt     = 3'd0;
               w_tmo_nxt     = TMO_LOAD;
               w_err_nxt     = 1'b0;
               w_err_idx_nxt = 3'd0;
               w_latch       = 1'b1;
            end
         end
         S_WR: begin
            if (wbm_ack_i) begin
               w_state_nxt = S_WR_GAP;
            end else if (r_tmo == 16'd0) begin
               w_state_nxt   = S_FIN;
               w_err_nxt     = 1'b1;
               w_err_idx_nxt = r_idx;
            end else begin
               w_tmo_nxt = r_tmo - 16'd1;
            end
         end
`ifdef BQLOAD_VERIFY_EN
         S_WR_GAP: begin
            w_state_nxt = S_RD;
            w_tmo_nxt   = TMO_LOAD;
         end
         S_RD: begin
            if (wbm_ack_i) begin
               if (wbm_dat_i[15:0] != r_coef[r_idx]) begin
                  w_state_nxt   = S_FIN;
                  w_err_nxt     = 1'b1;
                  w_err_idx_nxt = r_idx;
               end else begin
                  w_state_nxt = S_RD_GAP;
               end
            end else if (r_tmo == 16'd0) begin
               w_state_nxt   = S_FIN;
               w_err_nxt     = 1'b1;
               w_err_idx_nxt = r_idx;
            end else begin
               w_tmo_nxt = r_tmo - 16'd1;
            end
         end
         S_RD_GAP: begin
            if (r_idx == IDX_LAST) begin
               w_state_nxt = S_FIN;
            end else begin
               w_state_nxt = S_WR;
               w_idx_nxt   = r_idx + 3'd1;
               w_tmo_nxt   = TMO_LOAD;
            end
         end
`else
         S_WR_GAP: begin
            if (r_idx == IDX_LAST) begin
               w_state_nxt = S_FIN;
            end else begin
               w_state_nxt = S_WR;
               w_idx_nxt   = r_idx + 3'd1;
               w_tmo_nxt   = TMO_LOAD;
            end
         end
`endif
         S_FIN: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state view so the bus sees them one edge after the decision.
   always_comb begin
      w_xfer_nxt = (w_state_nxt == S_WR) || (w_state_nxt == S_RD);
      w_we_nxt   = (w_state_nxt == S_WR);
      w_busy_nxt = (w_state_nxt == S_WR) || (w_state_nxt == S_WR_GAP) ||
                   (w_state_nxt == S_RD) || (w_state_nxt == S_RD_GAP);
      w_adr_nxt  = BASE_ADR + ADR_STEP * {29'd0, w_idx_nxt};
      w_coef_sel = w_latch ? a11_i : r_coef[w_idx_nxt];
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state   <= S_IDLE;
         r_idx     <= 3'd0;
         r_tmo     <= 16'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_err_idx <= 3'd0;
         r_cyc     <= 1'b0;
         r_stb     <= 1'b0;
         r_we      <= 1'b0;
         r_adr     <= 32'd0;
         r_dat     <= 32'd0;
         for (int i = 0; i < 5; i++) r_coef[i] <= 16'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_tmo     <= w_tmo_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= (w_state_nxt == S_FIN);
         r_err     <= w_err_nxt;
         r_err_idx <= w_err_idx_nxt;
         r_cyc     <= w_xfer_nxt;
         r_stb     <= w_xfer_nxt;
         r_we      <= w_we_nxt;
         if (w_xfer_nxt) begin
            r_adr <= w_adr_nxt;
            r_dat <= {16'h0000, w_coef_sel};
         end
         if (w_latch) begin
            r_coef[0] <= a11_i;
            r_coef[1] <= a12_i;
            r_coef[2] <= b10_i;
            r_coef[3] <= b11_i;
            r_coef[4] <= b12_i;
         end
      end
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign err_o     = r_err;
   assign err_idx_o = r_err_idx;
   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_stb;
   assign wbm_we_o  = r_we;
   assign wbm_adr_o = r_adr;
   assign wbm_dat_o = r_dat;

endmodule

// File: tb/tb_bq_coef_loader.sv
// Directed bench for bq_coef_loader: two instances (unit-step and 0x3000_0000/step-4) against a simple Wishbone slave model.
module tb_bq_coef_loader;

`ifdef BQLOAD_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  start;
   logic [15:0] a11, a12, b10, b11, b12;
   logic [1:0]  busy, done, err, cyc, stb, we, ack;
   logic [2:0]  err_idx [2];
   logic [31:0] adr [2];
   logic [31:0] dat_o [2];
   logic [31:0] dat_i [2];

   int total = 0;
   int bad   = 0;

   bq_coef_loader #(.BASE_ADR(32'h0), .ADR_STEP(32'h1), .TIMEOUT(16)) u_dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start[0]),
      .a11_i(a11), .a12_i(a12), .b10_i(b10), .b11_i(b11), .b12_i(b12),
      .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .err_idx_o(err_idx[0]),
      .wbm_cyc_o(cyc[0]), .wbm_stb_o(stb[0]), .wbm_we_o(we[0]), .wbm_adr_o(adr[0]),
      .wbm_dat_o(dat_o[0]), .wbm_dat_i(dat_i[0]), .wbm_ack_i(ack[0]));

   bq_coef_loader #(.BASE_ADR(32'h3000_0000), .ADR_STEP(32'h4), .TIMEOUT(16)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start[1]),
      .a11_i(a11), .a12_i(a12), .b10_i(b10), .b11_i(b11), .b12_i(b12),
      .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .err_idx_o(err_idx[1]),
      .wbm_cyc_o(cyc[1]), .wbm_stb_o(stb[1]), .wbm_we_o(we[1]), .wbm_adr_o(adr[1]),
      .wbm_dat_o(dat_o[1]), .wbm_dat_i(dat_i[1]), .wbm_ack_i(ack[1]));

   // slave model state
   int          waits [2];
   int          noack_idx [2];
   int          bad_rd_idx [2];
   logic [1:0]  force_ack;
   logic [1:0]  clr;
   logic [15:0] mem [2][5];
   int          wcnt [2];
   int          wr_cnt [2];
   logic [31:0] log_adr [2][8];
   logic [31:0] log_dat [2][8];
   int          unstable [2];
   logic        prev_stb [2];
   logic        prev_ack [2];
   logic        prev_we [2];
   logic [31:0] prev_adr [2];
   logic [31:0] prev_dat [2];
   int          sidx [2];
   logic [15:0] exp_c [5];

   function automatic int slv_idx(input int s, input logic [31:0] a);
      logic [31:0] off;
      off = (s == 0) ? a : ((a - 32'h3000_0000) >> 2);
      if (off > 32'd4) return 7;
      return int'(off);
   endfunction

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         sidx[s]  = slv_idx(s, adr[s]);
         ack[s]   = force_ack[s] | (cyc[s] & stb[s] & (wcnt[s] == waits[s]) & (sidx[s] != noack_idx[s]));
         dat_i[s] = 32'hABCD_0000;
         if (sidx[s] < 5 && sidx[s] != bad_rd_idx[s]) dat_i[s] = {16'hABCD, mem[s][sidx[s]]};
      end
   end

   always @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (clr[s]) begin
            for (int i = 0; i < 5; i++) mem[s][i] <= 16'hDEAD;
            wr_cnt[s]   <= 0;
            unstable[s] <= 0;
            wcnt[s]     <= 0;
         end else begin
            if (cyc[s] && stb[s] && ack[s] && we[s] && sidx[s] < 5) begin
               mem[s][sidx[s]] <= dat_o[s][15:0];
               if (wr_cnt[s] < 8) begin
                  log_adr[s][wr_cnt[s]] <= adr[s];
                  log_dat[s][wr_cnt[s]] <= dat_o[s];
               end
               wr_cnt[s] <= wr_cnt[s] + 1;
            end
            if (stb[s] && !ack[s]) wcnt[s] <= wcnt[s] + 1;
            else                   wcnt[s] <= 0;
            if (stb[s] && prev_stb[s] && !prev_ack[s] &&
                (adr[s] != prev_adr[s] || dat_o[s] != prev_dat[s] || we[s] != prev_we[s]))
               unstable[s] <= unstable[s] + 1;
         end
         prev_stb[s] <= stb[s];
         prev_ack[s] <= ack[s];
         prev_we[s]  <= we[s];
         prev_adr[s] <= adr[s];
         prev_dat[s] <= dat_o[s];
      end
   end

   task automatic set_coefs(input logic [15:0] c0, c1, c2, c3, c4);
      a11 = c0; a12 = c1; b10 = c2; b11 = c3; b12 = c4;
      exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2; exp_c[3] = c3; exp_c[4] = c4;
   endtask

   task automatic slave_reset(input int s, input int w);
      waits[s] = w; noack_idx[s] = -1; bad_rd_idx[s] = -1; force_ack[s] = 1'b0;
      @(negedge clk); clr[s] = 1'b1;
      @(negedge clk); clr[s] = 1'b0;
   endtask

   // Start at edge N, then k counts negedges: k=1 falls in cycle N+1.
   task automatic run_seq(input int s, input int limit, input bit poke,
                          output int k_done, output int stb_cyc, output logic busy1);
      k_done = -1; stb_cyc = 0; busy1 = 1'b0;
      @(negedge clk); start[s] = 1'b1;
      @(posedge clk); #1 start[s] = 1'b0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (k == 1) busy1 = busy[s];
         if (stb[s]) stb_cyc++;
         if (poke && k == 3) begin
            start[s] = 1'b1;
            a11 = 16'h7777; a12 = 16'h7777; b10 = 16'h7777; b11 = 16'h7777; b12 = 16'h7777;
         end
         if (poke && k == 4) start[s] = 1'b0;
         if (done[s]) begin
            k_done = k;
            if (poke) start[s] = 1'b1;
            break;
         end
      end
      if (poke) begin
         @(negedge clk); start[s] = 1'b0;
      end
   endtask

   task automatic check_log(input string tag, input int s, input logic [31:0] base, input logic [31:0] step);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (log_adr[s][i] !== base + step * i) begin
            bad++; $display("FAIL %s adr[%0d] got=%h exp=%h", tag, i, log_adr[s][i], base + step * i);
         end
         total++;
         if (log_dat[s][i] !== {16'h0000, exp_c[i]}) begin
            bad++; $display("FAIL %s dat[%0d] got=%h exp=%h", tag, i, log_dat[s][i], {16'h0000, exp_c[i]});
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         total++;
         if ({cyc[s], stb[s], we[s], busy[s], done[s], err[s]} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl[%0d] got=%b exp=000000", s, {cyc[s], stb[s], we[s], busy[s], done[s], err[s]});
         end
         total++;
         if (adr[s] !== 32'h0 || dat_o[s] !== 32'h0 || err_idx[s] !== 3'd0) begin
            bad++; $display("FAIL reset_bus[%0d] got adr=%h dat=%h idx=%0d exp 0", s, adr[s], dat_o[s], err_idx[s]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_wait;
      int kd, sc; logic b1;
      slave_reset(0, 0);
      set_coefs(16'h4001, 16'hC000, 16'h2000, 16'h0001, 16'hFFFF);
      run_seq(0, 80, 1'b0, kd, sc, b1);
      total++;
      if (kd !== (VER ? 21 : 11)) begin bad++; $display("FAIL zw_done_cycle got=%0d exp=%0d", kd, VER ? 21 : 11); end
      total++;
      if (sc !== (VER ? 10 : 5)) begin bad++; $display("FAIL zw_stb_cycles got=%0d exp=%0d", sc, VER ? 10 : 5); end
      total++;
      if (b1 !== 1'b1 || busy[0] !== 1'b0) begin bad++; $display("FAIL zw_busy got first=%b at_done=%b exp 1/0", b1, busy[0]); end
      total++;
      if (err[0] !== 1'b0 || err_idx[0] !== 3'd0) begin bad++; $display("FAIL zw_err got=%b/%0d exp=0/0", err[0], err_idx[0]); end
      total++;
      if (wr_cnt[0] !== 5) begin bad++; $display("FAIL zw_wr_count got=%0d exp=5", wr_cnt[0]); end
      check_log("zw", 0, 32'h0, 32'h1);
   endtask

   task automatic test_wait_states;
      int kd, sc; logic b1;
      slave_reset(1, 3);
      set_coefs(16'h1111, 16'h8002, 16'h7FFF, 16'h8000, 16'h0123);
      run_seq(1, 150, 1'b0, kd, sc, b1);
      total++;
      if (kd !== (VER ? 51 : 26)) begin bad++; $display("FAIL ws_done_cycle got=%0d exp=%0d", kd, VER ? 51 : 26); end
      total++;
      if (sc !== (VER ? 40 : 20)) begin bad++; $display("FAIL ws_stb_cycles got=%0d exp=%0d", sc, VER ? 40 : 20); end
      total++;
      if (unstable[1] !== 0) begin bad++; $display("FAIL ws_stable got=%0d exp=0", unstable[1]); end
      total++;
      if (err[1] !== 1'b0 || wr_cnt[1] !== 5) begin bad++; $display("FAIL ws_status got err=%b wr=%0d exp 0/5", err[1], wr_cnt[1]); end
      check_log("ws", 1, 32'h3000_0000, 32'h4);
   endtask

   task automatic test_timeout;
      int kd, sc; logic b1;
      slave_reset(0, 0);
      noack_idx[0] = 2;
      set_coefs(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E);
      run_seq(0, 120, 1'b0, kd, sc, b1);
      total++;
      if (kd !== (VER ? 25 : 21)) begin bad++; $display("FAIL to_done_cycle got=%0d exp=%0d", kd, VER ? 25 : 21); end
      total++;
      if (sc !== (VER ? 20 : 18)) begin bad++; $display("FAIL to_stb_cycles got=%0d exp=%0d", sc, VER ? 20 : 18); end
      total++;
      if (err[0] !== 1'b1 || err_idx[0] !== 3'd2) begin bad++; $display("FAIL to_err got=%b/%0d exp=1/2", err[0], err_idx[0]); end
      total++;
      if (cyc[0] !== 1'b0 || stb[0] !== 1'b0) begin bad++; $display("FAIL to_bus_drop got=%b%b exp=00", cyc[0], stb[0]); end
      total++;
      if (wr_cnt[0] !== 2 || mem[0][3] !== 16'hDEAD || mem[0][4] !== 16'hDEAD) begin
         bad++; $display("FAIL to_untouched got wr=%0d m3=%h m4=%h exp 2/DEAD/DEAD", wr_cnt[0], mem[0][3], mem[0][4]);
      end
   endtask

`ifdef BQLOAD_VERIFY_EN
   task automatic test_mismatch;
      int kd, sc; logic b1;
      slave_reset(0, 0);
      bad_rd_idx[0] = 3;
      set_coefs(16'h4001, 16'hC000, 16'h2000, 16'h0001, 16'hFFFF);
      run_seq(0, 80, 1'b0, kd, sc, b1);
      total++;
      if (kd !== 16) begin bad++; $display("FAIL mm_done_cycle got=%0d exp=16", kd); end
      total++;
      if (err[0] !== 1'b1 || err_idx[0] !== 3'd3) begin bad++; $display("FAIL mm_err got=%b/%0d exp=1/3", err[0], err_idx[0]); end
      total++;
      if (wr_cnt[0] !== 4 || mem[0][4] !== 16'hDEAD) begin bad++; $display("FAIL mm_no_b12 got wr=%0d m4=%h exp 4/DEAD", wr_cnt[0], mem[0][4]); end
   endtask
`endif

   task automatic test_reset_mid;
      int kd, sc, nd; logic b1;
      slave_reset(0, 3);
      set_coefs(16'h5555, 16'hAAAA, 16'h3333, 16'hCCCC, 16'h0F0F);
      @(negedge clk); start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      repeat (VER ? 12 : 7) @(negedge clk);
      total++;
      if (stb[0] !== 1'b1 || we[0] !== 1'b1 || adr[0] !== 32'h1) begin
         bad++; $display("FAIL rm_second_write got stb=%b we=%b adr=%h exp 1/1/1", stb[0], we[0], adr[0]);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({cyc[0], stb[0], we[0], busy[0], done[0], err[0]} !== 6'b0 || adr[0] !== 32'h0 || dat_o[0] !== 32'h0) begin
         bad++; $display("FAIL rm_outputs got ctl=%b adr=%h dat=%h exp 0", {cyc[0], stb[0], we[0], busy[0], done[0], err[0]}, adr[0], dat_o[0]);
      end
      rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done[0] || busy[0] || cyc[0]) nd++;
      end
      total++;
      if (nd !== 0) begin bad++; $display("FAIL rm_quiet got=%0d exp=0", nd); end
      slave_reset(0, 0);
      run_seq(0, 80, 1'b0, kd, sc, b1);
      total++;
      if (kd !== (VER ? 21 : 11) || err[0] !== 1'b0 || wr_cnt[0] !== 5) begin
         bad++; $display("FAIL rm_reload got done=%0d err=%b wr=%0d exp %0d/0/5", kd, err[0], wr_cnt[0], VER ? 21 : 11);
      end
      check_log("rm", 0, 32'h0, 32'h1);
   endtask

   task automatic test_ignore;
      int kd, sc, nd; logic b1;
      slave_reset(0, 0);
      force_ack[0] = 1'b1;
      repeat (2) @(negedge clk);
      force_ack[0] = 1'b0;
      total++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || cyc[0] !== 1'b0) begin
         bad++; $display("FAIL ig_idle_ack got busy=%b done=%b cyc=%b exp 0", busy[0], done[0], cyc[0]);
      end
      set_coefs(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F);
      run_seq(0, 80, 1'b1, kd, sc, b1);
      total++;
      if (kd !== (VER ? 21 : 11)) begin bad++; $display("FAIL ig_done_cycle got=%0d exp=%0d", kd, VER ? 21 : 11); end
      total++;
      if (wr_cnt[0] !== 5) begin bad++; $display("FAIL ig_wr_count got=%0d exp=5", wr_cnt[0]); end
      check_log("ig", 0, 32'h0, 32'h1);
      nd = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done[0] || busy[0] || stb[0]) nd++;
      end
      total++;
      if (nd !== 0) begin bad++; $display("FAIL ig_start_on_done got=%0d exp=0", nd); end
   endtask

   initial begin
      rst = 1'b1; start = 2'b00; force_ack = 2'b00; clr = 2'b00;
      for (int s = 0; s < 2; s++) begin
         waits[s] = 0; noack_idx[s] = -1; bad_rd_idx[s] = -1;
      end
      set_coefs(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_timeout();
`ifdef BQLOAD_VERIFY_EN
      test_mismatch();
`endif
      test_reset_mid();
      test_ignore();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
